// File: rtl/fp8_log2_unpack.sv
// ----------------------------------------------------------------------------
// fp8_log2_unpack
//
// Purpose:
//   Streaming front-end for the float8 log2 path. It accepts raw e4m3 operands
//   and decodes each one into the (is_subnormal, exp_val) pair used by the
//   downstream int-to-float8 exponent converter. It also flags zero, NaN and
//   negative operands (log2 is undefined for negative operands).
//   The block is a two-stage registered pipeline with a valid/ready handshake
//   at both ends. It sustains one operand per cycle with no bubbles.
//
// Parameters:
//   NAN_MODE : 0 = e4m3fn, where only S.1111.111 is NaN.
//              1 = every exponent=1111 encoding is NaN.
//   CNT_W    : width of the statistics counters.
//
// Optional feature (macro FP8_LOG2_STATS_EN):
//   When the macro is defined, three saturating counters count the output
//   handshakes that carry the NaN, zero or negative flag. stats_clr clears
//   all three counters. When the macro is undefined, the counter outputs
//   are tied to 0 and stats_clr is ignored.
//
// Ports:
//   clk              in   clock; all state changes on the rising edge
//   rst              in   synchronous, active-high reset
//   in_valid         in   upstream operand valid
//   in_ready         out  block accepts an operand this cycle
//   in_data[7:0]     in   e4m3 operand {sign, exp[3:0], mant[2:0]}
//   out_valid        out  decoded result valid
//   out_ready        in   downstream accepts the result
//   out_is_subnormal out  out_exp_val carries the subnormal mantissa
//   out_exp_val[3:0] out  exponent field, or {1'b0, mant} when subnormal
//   out_sign         out  sign bit of the operand
//   out_is_zero      out  operand is +/-0
//   out_is_nan       out  operand is NaN under NAN_MODE
//   out_neg          out  sign set, and the operand is neither zero nor NaN
//   stats_clr        in   clear the statistics counters
//   nan_cnt          out  saturating NaN counter      (CNT_W bits)
//   zero_cnt         out  saturating zero counter     (CNT_W bits)
//   neg_cnt          out  saturating negative counter (CNT_W bits)
// ----------------------------------------------------------------------------
module fp8_log2_unpack #(
    parameter int NAN_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_subnormal,
    output logic [3:0]       out_exp_val,
    output logic             out_sign,
    output logic             out_is_zero,
    output logic             out_is_nan,
    output logic             out_neg,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] nan_cnt,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] neg_cnt
);

    // Stage 1: raw operand.
    logic       r_s1_valid;
    logic [7:0] r_s1_data;

    // Stage 2: decoded fields. These flops drive the outputs directly.
    logic       r_s2_valid;
    logic       r_sub;
    logic [3:0] r_exp;
    logic       r_sign;
    logic       r_zero;
    logic       r_nan;
    logic       r_neg;

    // Ready chain. Each stage can advance when it is empty or when the stage
    // after it can advance. No path exists from in_valid to any output.
    logic w_s2_en;
    logic w_s1_en;

    assign w_s2_en  = ~r_s2_valid | out_ready;
    assign w_s1_en  = ~r_s1_valid | w_s2_en;
    assign in_ready = w_s1_en;

    // Decode of the operand held in stage 1.
    logic [3:0] w_e;
    logic [2:0] w_m;
    logic       w_sub;
    logic [3:0] w_exp;
    logic       w_zero;
    logic       w_nan;
    logic       w_neg;

    assign w_e    = r_s1_data[6:3];
    assign w_m    = r_s1_data[2:0];
    assign w_sub  = (w_e == 4'd0);
    // A subnormal operand passes its mantissa to the converter in place of
    // the exponent field.
    assign w_exp  = w_sub ? {1'b0, w_m} : w_e;
    assign w_zero = w_sub & (w_m == 3'd0);
    assign w_nan  = (NAN_MODE != 0) ? (w_e == 4'hF)
                                    : ((w_e == 4'hF) & (w_m == 3'h7));
    assign w_neg  = r_s1_data[7] & ~w_zero & ~w_nan;

    // NOTE: all state uses non-blocking assignments. Every flop then samples
    // the values from before the edge, so stage 2 reads the old stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 8'h00;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
            end
        end
    end

    // NOTE: the datapath registers are reset along with the valid bits, so
    // the outputs read as 0 after reset and not as a stale value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_sub      <= 1'b0;
            r_exp      <= 4'd0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_nan      <= 1'b0;
            r_neg      <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sub  <= w_sub;
                r_exp  <= w_exp;
                r_sign <= r_s1_data[7];
                r_zero <= w_zero;
                r_nan  <= w_nan;
                r_neg  <= w_neg;
            end
        end
    end

    assign out_valid        = r_s2_valid;
    assign out_is_subnormal = r_sub;
    assign out_exp_val      = r_exp;
    assign out_sign         = r_sign;
    assign out_is_zero      = r_zero;
    assign out_is_nan       = r_nan;
    assign out_neg          = r_neg;

`ifdef FP8_LOG2_STATS_EN
    logic             w_pop;
    logic [CNT_W-1:0] r_nan_cnt;
    logic [CNT_W-1:0] r_zero_cnt;
    logic [CNT_W-1:0] r_neg_cnt;

    assign w_pop = r_s2_valid & out_ready;

    // A clear takes priority over an increment in the same cycle. Each
    // counter stops at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_nan_cnt  <= '0;
            r_zero_cnt <= '0;
            r_neg_cnt  <= '0;
        end else if (w_pop) begin
            if (r_nan && (r_nan_cnt != '1)) begin
                r_nan_cnt <= r_nan_cnt + CNT_W'(1);
            end
            if (r_zero && (r_zero_cnt != '1)) begin
                r_zero_cnt <= r_zero_cnt + CNT_W'(1);
            end
            if (r_neg && (r_neg_cnt != '1)) begin
                r_neg_cnt <= r_neg_cnt + CNT_W'(1);
            end
        end
    end

    assign nan_cnt  = r_nan_cnt;
    assign zero_cnt = r_zero_cnt;
    assign neg_cnt  = r_neg_cnt;
`else
    logic w_unused_stats_clr;

    assign w_unused_stats_clr = stats_clr;
    assign nan_cnt  = '0;
    assign zero_cnt = '0;
    assign neg_cnt  = '0;
`endif

endmodule

// File: tb/tb_fp8_log2_unpack.sv
// ----------------------------------------------------------------------------
// tb_fp8_log2_unpack
//
// Testbench for fp8_log2_unpack. It instantiates two copies of the design,
// one with NAN_MODE=0 and one with NAN_MODE=1, and drives both from the same
// stimulus. Both copies use CNT_W=2.
//
// The reference model holds a queue of accepted operands. An operand
// accepted during cycle c appears at the output from cycle c+2 onward, once
// it is the oldest operand in the pipe. The pipe holds at most two operands.
// The model recomputes each expected decode from the e4m3 field rules.
// Counter expectations follow the FP8_LOG2_STATS_EN macro.
// ----------------------------------------------------------------------------
module tb_fp8_log2_unpack;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       sub;
        logic [3:0] exp;
        logic       sign;
        logic       zero;
        logic       nan;
        logic       neg;
    } dec_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             out_ready;
    logic             stats_clr;

    logic             in_ready  [2];
    logic             out_valid [2];
    logic             o_sub     [2];
    logic [3:0]       o_exp     [2];
    logic             o_sign    [2];
    logic             o_zero    [2];
    logic             o_nan     [2];
    logic             o_neg     [2];
    logic [CNT_W-1:0] o_nan_cnt [2];
    logic [CNT_W-1:0] o_zero_cnt[2];
    logic [CNT_W-1:0] o_neg_cnt [2];

    always #5 clk = ~clk;

    fp8_log2_unpack #(.NAN_MODE(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_is_subnormal(o_sub[0]), .out_exp_val(o_exp[0]),
        .out_sign(o_sign[0]), .out_is_zero(o_zero[0]),
        .out_is_nan(o_nan[0]), .out_neg(o_neg[0]),
        .stats_clr(stats_clr),
        .nan_cnt(o_nan_cnt[0]), .zero_cnt(o_zero_cnt[0]), .neg_cnt(o_neg_cnt[0])
    );

    fp8_log2_unpack #(.NAN_MODE(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_is_subnormal(o_sub[1]), .out_exp_val(o_exp[1]),
        .out_sign(o_sign[1]), .out_is_zero(o_zero[1]),
        .out_is_nan(o_nan[1]), .out_neg(o_neg[1]),
        .stats_clr(stats_clr),
        .nan_cnt(o_nan_cnt[1]), .zero_cnt(o_zero_cnt[1]), .neg_cnt(o_neg_cnt[1])
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    entry_t q[$];
    int     m_nan [2];
    int     m_zero[2];
    int     m_neg [2];

    // Reference decode, computed arithmetically from the e4m3 fields.
    function automatic dec_t ref_dec(input int x, input int mode);
        dec_t r;
        int   s;
        int   e;
        int   m;
        s = x / 128;
        e = (x / 8) % 16;
        m = x % 8;
        r.sub  = (e == 0);
        r.exp  = (e == 0) ? 4'(m) : 4'(e);
        r.sign = (s == 1);
        r.zero = (e == 0) && (m == 0);
        r.nan  = (mode == 1) ? (e == 15) : ((e == 15) && (m == 7));
        r.neg  = r.sign && !r.zero && !r.nan;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs one clock cycle. Inputs must already be stable. The task samples
    // and checks the outputs at the falling edge, applies the handshakes to
    // the model, and returns #1 after the next rising edge.
    task automatic step();
        bit   exp_ready;
        bit   exp_ov;
        dec_t d;
        @(negedge clk);
        if (rst) begin
            q.delete();
            for (int k = 0; k < 2; k++) begin
                m_nan[k] = 0; m_zero[k] = 0; m_neg[k] = 0;
            end
        end else begin
            exp_ready = (q.size() < 2) || out_ready;
            exp_ov    = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d in_ready", k), 32'(in_ready[k]), 32'(exp_ready));
                chk($sformatf("dut%0d out_valid", k), 32'(out_valid[k]), 32'(exp_ov));
                if (exp_ov) begin
                    d = ref_dec(int'(q[0].data), k);
                    chk($sformatf("dut%0d decode of %02h", k, q[0].data),
                        32'({o_sub[k], o_exp[k], o_sign[k], o_zero[k], o_nan[k], o_neg[k]}),
                        32'(d));
                end
`ifdef FP8_LOG2_STATS_EN
                chk($sformatf("dut%0d nan_cnt", k), 32'(o_nan_cnt[k]), 32'(m_nan[k]));
                chk($sformatf("dut%0d zero_cnt", k), 32'(o_zero_cnt[k]), 32'(m_zero[k]));
                chk($sformatf("dut%0d neg_cnt", k), 32'(o_neg_cnt[k]), 32'(m_neg[k]));
`else
                chk($sformatf("dut%0d counters", k),
                    32'({o_nan_cnt[k], o_zero_cnt[k], o_neg_cnt[k]}), 32'(0));
`endif
            end
            // Counter update. A clear wins over a same-cycle increment.
            for (int k = 0; k < 2; k++) begin
                if (stats_clr) begin
                    m_nan[k] = 0; m_zero[k] = 0; m_neg[k] = 0;
                end else if (exp_ov && out_ready) begin
                    d = ref_dec(int'(q[0].data), k);
                    if (d.nan  && m_nan[k]  < CNT_MAX) m_nan[k]++;
                    if (d.zero && m_zero[k] < CNT_MAX) m_zero[k]++;
                    if (d.neg  && m_neg[k]  < CNT_MAX) m_neg[k]++;
                end
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) q.push_back('{data: in_data, cyc: cyc});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [7:0] specials[8];
        specials = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h78, 8'hF8, 8'h01, 8'hC0};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; stats_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_nan[k] = 0; m_zero[k] = 0; m_neg[k] = 0;
        end
        step(); step();
        rst = 1'b0;
        // Reset state: the data fields read 0.
        for (int k = 0; k < 2; k++)
            chk($sformatf("dut%0d reset fields", k),
                32'({o_sub[k], o_exp[k], o_sign[k], o_zero[k], o_nan[k], o_neg[k]}), 32'(0));

        // Basic stream with out_ready held high.
        push(8'h38); push(8'h05); push(8'h00); push(8'h7F);
        idle(3);

        // Fill the pipe while stalled, then pop one result and push one operand.
        out_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h33);
        out_ready = 1'b1;
        push(8'h33);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step(); step();
        out_ready = 1'b1;
        idle(4);

        // Sign and negative flags, plus the NaN difference between the modes.
        push(8'hC0); push(8'h80); push(8'h78); push(8'hF8);
        idle(3);

        // Reset with both stages full. The held data must never appear.
        out_ready = 1'b0;
        push(8'h44); push(8'h55);
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Five NaNs saturate a 2-bit counter.
        for (int i = 0; i < 5; i++) push(8'hFF);
        idle(3);
        // stats_clr coincides with a NaN handshake.
        push(8'h7F);
        idle(1);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        idle(3);

        // Random traffic with handshake backpressure, occasional clears and
        // one mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 7)]
                                                    : 8'($urandom);
            stats_clr = ($urandom_range(0, 31) == 0);
            rst       = (i == 300);
            step();
        end
        rst = 1'b0; stats_clr = 1'b0; out_ready = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
